// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a single shared memory port and drives datapath selects and strobes.
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       link,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       signext,
    output logic       shiftl16,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB = 4'd4, MEMWR = 4'd5, REX = 4'd6, RWB = 4'd7,
        BRANCH = 4'd8, IEX = 4'd9, IWB = 4'd10, JUMP = 4'd11,
        JAL = 4'd12, JR = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR = 3'b001, ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   pcwrite, branch, nez;

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        nez        = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        link       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        signext    = 1'b0;
        shiftl16   = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = ALU_AND;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                memread    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // ALUOut captures PC+4 + (imm<<2) so BRANCH can use it directly
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                signext    = 1'b1;
                case (op)
                    6'b100011, 6'b101011:                       state_d = MEMADR;
                    6'b000100, 6'b000101:                       state_d = BRANCH;
                    6'b001000, 6'b001001, 6'b001101, 6'b001111: state_d = IEX;
                    6'b000010:                                  state_d = JUMP;
                    6'b000011:                                  state_d = JAL;
                    6'b000000: begin
                        case (funct)
                            6'b001000: state_d = JR;
                            6'b100000, 6'b100001, 6'b100010, 6'b100011,
                            6'b100100, 6'b100101, 6'b101010: state_d = REX;
                            default: begin
                                illegal = 1'b1;
                                state_d = FETCH;
                            end
                        endcase
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                signext    = 1'b1;
                alucontrol = ALU_ADD;
                state_d    = (op == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            REX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010, 6'b100011: alucontrol = ALU_SUB;
                    6'b100100:            alucontrol = ALU_AND;
                    6'b100101:            alucontrol = ALU_OR;
                    6'b101010:            alucontrol = ALU_SLT;
                    default:              alucontrol = ALU_ADD;
                endcase
                state_d = RWB;
            end
            RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                nez        = (op == 6'b000101);
                state_d    = FETCH;
            end
            IEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    6'b001101: alucontrol = ALU_OR;
                    6'b001111: begin
                        alucontrol = ALU_OR;
                        shiftl16   = 1'b1;
                    end
                    default: begin
                        alucontrol = ALU_ADD;
                        signext    = 1'b1;
                    end
                endcase
                state_d = IWB;
            end
            IWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                link     = 1'b1;
                state_d  = FETCH;
            end
            JR: begin
                pcsrc   = 2'b11;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        pcen = pcwrite | (branch & (zero ^ nez));
        // State is already FETCH during reset; mask its strobes so nothing fires
        if (!reset_n) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            memread  = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    assign state = state_q;
endmodule
